btn_debounce_repeat: RTL and testbench
======================================

Name: btn_debounce_repeat

Overview:
- Downstream consumer of the 1 ms tick from the board clock divider. Debounces N raw push-buttons on the tick timebase.
- Per button, emits a stable level, single-clock press/release pulses, and auto-repeat pulses while held.
- Feeds the CPU single-step, reset-request and display-select logic, all in the same clk domain.

Parameters:
N_BTN, 4, number of independent buttons
STABLE_MS, 20, consecutive ticks of a steady input needed to accept a new level (≥1)
REPEAT_DELAY_MS, 500, ticks from accepted press to first repeat pulse (≥1)
REPEAT_RATE_MS, 100, ticks between subsequent repeat pulses (≥1)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
tick_1ms  input  1  one-clk-wide pulse every 1 ms, from the divider, synchronous to clk
btn_raw  input  N_BTN  raw asynchronous button pins, active-high
btn_level  output  N_BTN  debounced level
btn_press  output  N_BTN  1-clk pulse on accepted 0→1
btn_release  output  N_BTN  1-clk pulse on accepted 1→0
btn_repeat  output  N_BTN  1-clk pulse per auto-repeat event

Behaviour:
- Reset (reset=0, async): sync FFs=0, btn_level=0, all pulse outputs=0, all counters=0, every repeat FSM=IDLE. Reset may assert mid-count or mid-repeat. On release of reset, operation resumes from this state on the next posedge.
- Synchronizer: 2-FF chain per bit, giving s[i]. All later logic uses s[i] only. This adds 2 clk of latency.
- Debounce, per bit i, with counter dcnt sized to hold STABLE_MS-1:
  - If s[i]==btn_level[i]: dcnt<=0 every clk, whether or not a tick is present. Any bounce restarts the qualification.
  - Else, on a clk with tick_1ms=1:
    - if dcnt==STABLE_MS-1: btn_level[i]<=s[i], dcnt<=0, and a press or release pulse fires per direction;
    - otherwise dcnt<=dcnt+1.
  - No tick: dcnt holds.
- Pulses (press, release, repeat) are registered. Each is high for exactly the one clk after the accepting edge, then 0.
- Repeat FSM, per bit, with counter rcnt sized to hold max(REPEAT_DELAY_MS, REPEAT_RATE_MS)-1:
  - IDLE: on accepted press → DELAY, rcnt<=0.
  - DELAY: on tick, if rcnt==REPEAT_DELAY_MS-1 → fire repeat pulse, go to REPEAT, rcnt<=0; else rcnt+1.
  - REPEAT: on tick, if rcnt==REPEAT_RATE_MS-1 → fire repeat pulse, rcnt<=0; else rcnt+1.
  - From any state, an accepted release → IDLE, rcnt<=0.
  - If a release and a repeat terminal count land on the same clk, release wins: no repeat pulse.
- The tick that accepts a press does not advance rcnt. Counting starts on the following tick.
- Bits are fully independent. Simultaneous events on different bits are all reported in the same clk.
- No counter ever wraps: each is cleared at its terminal value.
- tick_1ms held high for several clk: each clk counts as a tick. This is not a legal input, and the block has no defense against it.
- Press latency: 2 clk plus STABLE_MS ticks from a stable edge on btn_raw to btn_press. Release latency is the same.

Test Plan (overrides: STABLE_MS=3, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, tick every 10 clk, N_BTN=4):
- Clean press: btn_raw[0] 0→1 and held → btn_press[0] is one 1-clk pulse, after the 3rd tick that follows sync. btn_level[0]=1 from the same clk. Other bits stay 0.
- Bounce: btn_raw[1] toggles every 7 clk for 60 clk, then held 1 → no pulses while toggling. Exactly one btn_press[1] about 3 ticks after settling.
- Auto-repeat: hold btn_raw[2]=1 for 15 ticks after acceptance → btn_repeat[2] at ticks 5, 7, 9, 11, 13, 15 after the press. Release → one btn_release[2] and no further repeats.
- Release/repeat collision: time the release acceptance onto a repeat terminal tick → btn_release pulse, no btn_repeat that clk, FSM IDLE.
- Async reset mid-repeat: drive reset=0 between clk edges while btn 2 is in REPEAT → all outputs 0 immediately. After reset=1 with the button still held, a fresh btn_press fires after 3 ticks.
- Simultaneous: btn_raw=4'b1011 applied at once → btn_press=4'b1011 in a single clk, btn_level=4'b1011.

Source files
------------

// File: rtl/btn_debounce_repeat.sv
// Debounces N_BTN raw push-buttons on the 1 ms tick timebase. Each button is
// synchronised into clk, qualified by STABLE_MS consecutive steady ticks, and
// reported as a debounced level plus one-clock press, release and auto-repeat
// pulses.
module btn_debounce_repeat #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned STABLE_MS       = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1ms,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int unsigned RepMax = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                      : REPEAT_RATE_MS;
  localparam int unsigned DcntW  = (STABLE_MS > 1) ? $clog2(STABLE_MS) : 1;
  localparam int unsigned RcntW  = (RepMax > 1) ? $clog2(RepMax) : 1;

  localparam logic [DcntW-1:0] DcntLast  = DcntW'(STABLE_MS - 1);
  localparam logic [RcntW-1:0] DelayLast = RcntW'(REPEAT_DELAY_MS - 1);
  localparam logic [RcntW-1:0] RateLast  = RcntW'(REPEAT_RATE_MS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rep_state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic [DcntW-1:0] dcnt_q  [N_BTN];
  logic [DcntW-1:0] dcnt_d  [N_BTN];
  logic [RcntW-1:0] rcnt_q  [N_BTN];
  logic [RcntW-1:0] rcnt_d  [N_BTN];
  rep_state_e       state_q [N_BTN];
  rep_state_e       state_d [N_BTN];

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count ticks of a steady mismatch, restart on any bounce.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        dcnt_d[i] = '0;
      end else if (tick_1ms) begin
        if (dcnt_q[i] == DcntLast) begin
          level_d[i]   = sync2_q[i];
          dcnt_d[i]    = '0;
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Auto-repeat next state; an accepted release overrides any terminal count.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (release_d[i]) begin
        state_d[i] = StIdle;
        rcnt_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (press_d[i]) begin
              state_d[i] = StDelay;
              rcnt_d[i]  = '0;
            end
          end
          StDelay: begin
            if (tick_1ms) begin
              if (rcnt_q[i] == DelayLast) begin
                repeat_d[i] = 1'b1;
                state_d[i]  = StRepeat;
                rcnt_d[i]   = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + 1'b1;
              end
            end
          end
          StRepeat: begin
            if (tick_1ms) begin
              if (rcnt_q[i] == RateLast) begin
                repeat_d[i] = 1'b1;
                rcnt_d[i]   = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + 1'b1;
              end
            end
          end
          default: begin
            state_d[i] = StIdle;
            rcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Level, registered pulses, counters and repeat state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        state_q[i] <= StIdle;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Bench for btn_debounce_repeat: directed scenarios plus random stimulus,
// compared each clock against a tick-counting reference model.
module tb_btn_debounce_repeat;

  localparam int NB = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;
  localparam int TP = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick_1ms = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  btn_debounce_repeat #(
    .N_BTN          (NB),
    .STABLE_MS      (ST),
    .REPEAT_DELAY_MS(RD),
    .REPEAT_RATE_MS (RR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1ms   (tick_1ms),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: pin history, accepted level, run of mismatched ticks,
  // and ticks elapsed since the accepted press (-1 when not held).
  logic [NB-1:0]   m_s1, m_s2, m_level;
  int              m_run  [NB];
  int              m_held [NB];
  logic [NB-1:0]   e_press, e_rel, e_rep;
  logic [4*NB-1:0] exp_v;
  bit              last_tick;
  logic [4*NB-1:0] dut_v;
  assign dut_v = {btn_level, btn_press, btn_release, btn_repeat};

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0;
    e_press = '0; e_rel = '0; e_rep = '0;
    for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_held[i] = -1; end
    exp_v = '0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] s;
    s = m_s2;
    e_press = '0; e_rel = '0; e_rep = '0;
    last_tick = tick_1ms;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        if (s[i] == m_level[i]) m_run[i] = 0;
        else if (tick_1ms) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            m_level[i] = s[i]; m_run[i] = 0;
            e_press[i] = s[i]; e_rel[i] = !s[i];
          end
        end
        if (e_rel[i]) m_held[i] = -1;
        else if (m_held[i] >= 0 && tick_1ms) begin
          m_held[i]++;
          if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RR == 0)) e_rep[i] = 1'b1;
        end
        if (e_press[i]) m_held[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
    exp_v = {m_level, e_press, e_rel, e_rep};
  endtask

  // One clock: model sees the pre-edge inputs, new inputs are set at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    tick_1ms = (cyc % TP == TP - 1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_v !== 16'h0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_v, 16'h0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_clean_press();
    int np = 0;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (btn_press[0]) np++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL clean_press cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (np !== 1) begin errors++; $display("FAIL clean_press_count got=%0d exp=1", np); end
    checks++;
    if (btn_level !== 4'b0001) begin
      errors++; $display("FAIL clean_press_level got=%b exp=0001", btn_level);
    end
  endtask

  task automatic test_bounce();
    int np_bounce = 0;
    int np = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 7 == 0) btn_raw[1] = ~btn_raw[1];
      step();
      if (btn_press[1] || btn_release[1]) np_bounce++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (btn_press[1]) np++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL bounce_settle cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (np_bounce !== 0) begin
      errors++; $display("FAIL bounce_quiet got=%0d pulses exp=0", np_bounce);
    end
    checks++;
    if (np !== 1) begin errors++; $display("FAIL bounce_press_count got=%0d exp=1", np); end
  endtask

  task automatic test_auto_repeat();
    bit seen = 0;
    int nrep = 0;
    int nrel = 0;
    int late_rep = 0;
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      seen = btn_press[2];
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL repeat_wait cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL repeat_press got=none exp=pulse"); end
    for (int k = 0; k < 15 * TP; k++) begin
      step();
      if (btn_repeat[2]) nrep++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL repeat_hold cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (nrep !== 6) begin errors++; $display("FAIL repeat_count got=%0d exp=6", nrep); end
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (nrel > 0 && btn_repeat[2]) late_rep++;
      if (btn_release[2]) nrel++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL repeat_release cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (nrel !== 1) begin errors++; $display("FAIL repeat_release_count got=%0d exp=1", nrel); end
    checks++;
    if (late_rep !== 0) begin
      errors++; $display("FAIL repeat_after_release got=%0d exp=0", late_rep);
    end
  endtask

  task automatic test_collision();
    bit seen = 0;
    bit hit = 0;
    int nticks = 0;
    int late_rep = 0;
    btn_raw[3] = 1'b1;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      seen = btn_press[3];
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL coll_wait cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    // Drop the pin right after the tick that makes held=6, so acceptance
    // lands 3 ticks later at held=9, a repeat terminal count.
    for (int k = 0; k < 200 && !hit; k++) begin
      step();
      hit = last_tick && (m_held[3] == 6);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL coll_hold cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL coll_align got=none exp=held6"); end
    btn_raw[3] = 1'b0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      if (last_tick) nticks++;
      seen = btn_release[3];
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL coll_release cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL coll_release_seen got=none exp=pulse"); end
    checks++;
    if (nticks !== 3) begin errors++; $display("FAIL coll_ticks got=%0d exp=3", nticks); end
    checks++;
    if (btn_repeat[3] !== 1'b0) begin
      errors++; $display("FAIL coll_no_repeat got=%b exp=0", btn_repeat[3]);
    end
    for (int k = 0; k < 50; k++) begin
      step();
      if (btn_repeat[3]) late_rep++;
    end
    checks++;
    if (late_rep !== 0) begin errors++; $display("FAIL coll_idle got=%0d exp=0", late_rep); end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    bit deep = 0;
    int np = 0;
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      seen = btn_press[2];
    end
    for (int k = 0; k < 200 && !deep; k++) begin
      step();
      deep = (m_held[2] >= 6);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL areset_pre cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (!deep) begin errors++; $display("FAIL areset_reach got=none exp=repeat_state"); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut_v !== 16'h0) begin
      errors++; $display("FAIL areset_immediate got=%h exp=%h", dut_v, 16'h0);
    end
    model_reset();
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (btn_press[2]) np++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL areset_after cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (np !== 1) begin errors++; $display("FAIL areset_press got=%0d exp=1", np); end
  endtask

  task automatic test_simultaneous();
    bit seen = 0;
    int idle;
    btn_raw = '0;
    for (int k = 0; k < 80; k++) step();
    idle = $urandom_range(0, TP - 1);
    for (int k = 0; k < idle; k++) step();
    btn_raw = 4'b1011;
    for (int k = 0; k < 80 && !seen; k++) begin
      step();
      seen = (btn_press != '0);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL simul cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (btn_press !== 4'b1011) begin
      errors++; $display("FAIL simul_press got=%b exp=1011", btn_press);
    end
    checks++;
    if (btn_level !== 4'b1011) begin
      errors++; $display("FAIL simul_level got=%b exp=1011", btn_level);
    end
  endtask

  task automatic test_random();
    int b;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        b = $urandom_range(0, NB - 1);
        btn_raw[b] = ~btn_raw[b];
      end
      step();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_collision();
    test_async_reset();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
